dot_product_sequencer: RTL and testbench

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

---
 rtl/dot_product_sequencer.sv | 118 +++++++++++
 tb/tb_dot_product_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Sequencer that streams two vector memories through a registered MAC.
// Define DOTP_SIGNED_EN for two's-complement operands (default: unsigned).
module dot_product_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  mem_busy,
   output logic                  rd_en_a,
   output logic                  rd_en_b,
   output logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [ADDR_WIDTH-1:0] rd_addr_b,
   input  logic [DATA_WIDTH-1:0] dout_a,
   input  logic [DATA_WIDTH-1:0] dout_b,
   output logic                  busy,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  result_valid,
   input  logic                  result_ready
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_e;

   localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam int                    PW       = 2*DATA_WIDTH;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  mac_en_q, mac_en_d;

   logic [ADDR_WIDTH:0]   len_clamp;
   logic                  last_rd;
   logic [ACC_WIDTH-1:0]  prod;

`ifdef DOTP_SIGNED_EN
   logic signed [PW-1:0]  prod_s;
   assign prod_s = $signed({{DATA_WIDTH{dout_a[DATA_WIDTH-1]}}, dout_a})
                 * $signed({{DATA_WIDTH{dout_b[DATA_WIDTH-1]}}, dout_b});
   assign prod   = {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s};
`else
   logic [PW-1:0]         prod_u;
   assign prod_u = {{DATA_WIDTH{1'b0}}, dout_a}
                 * {{DATA_WIDTH{1'b0}}, dout_b};
   assign prod   = {{(ACC_WIDTH-PW){1'b0}}, prod_u};
`endif

   assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
   assign last_rd   = (({1'b0, addr_q} + LEN_ONE) == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         mac_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         mac_en_q <= mac_en_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      acc_d        = acc_q;
      mac_en_d     = 1'b0;
      rd_en_a      = 1'b0;
      rd_en_b      = 1'b0;
      rd_addr_a    = '0;
      rd_addr_b    = '0;
      busy         = 1'b1;
      result       = '0;
      result_valid = 1'b0;
      // Read data lands one cycle after the strobe, so the MAC trails READ by one.
      if (mac_en_q) acc_d = acc_q + prod;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start && !mem_busy) begin
               acc_d   = '0;
               addr_d  = '0;
               len_d   = len_clamp;
               state_d = (len_clamp == '0) ? HOLD : READ;
            end
         end
         READ: begin
            rd_en_a   = 1'b1;
            rd_en_b   = 1'b1;
            rd_addr_a = addr_q;
            rd_addr_b = addr_q;
            mac_en_d  = 1'b1;
            addr_d    = addr_q + ADDR_ONE;
            if (last_rd) state_d = DRAIN;
         end
         DRAIN: state_d = HOLD;
         HOLD: begin
            result       = acc_q;
            result_valid = 1'b1;
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: directed and random jobs checked
// against an arithmetic dot-product model over bench-owned memories.
module tb_dot_product_sequencer;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int AC = 2*DW+AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW:0]   len;
   logic          mem_busy;
   logic          rd_en_a, rd_en_b;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic [DW-1:0] dout_a, dout_b;
   logic          busy;
   logic [AC-1:0] result;
   logic          result_valid;
   logic          result_ready;

   logic [DW-1:0] mem_a [32];
   logic [DW-1:0] mem_b [32];

   int checks = 0;
   int errors = 0;

   dot_product_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .mem_busy(mem_busy),
      .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .dout_a(dout_a), .dout_b(dout_b),
      .busy(busy), .result(result), .result_valid(result_valid),
      .result_ready(result_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en_a) dout_a <= mem_a[rd_addr_a];
      if (rd_en_b) dout_b <= mem_b[rd_addr_b];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AC-1:0] model(input int n);
      longint s;
      s = 0;
      for (int i = 0; i < n; i++) begin
`ifdef DOTP_SIGNED_EN
         s += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
`else
         s += longint'(mem_a[i]) * longint'(mem_b[i]);
`endif
      end
      return s[AC-1:0];
   endfunction

   task automatic run_job(input string tag, input int l,
                          input logic [AC-1:0] exp, input int hold,
                          input bit poke, input bit jitter);
      int eff, cyc, nrd, lat;
      eff = (l > 32) ? 32 : l;
      lat = (eff == 0) ? 1 : eff + 2;
      @(negedge clk);
      mem_busy = 1'b0;
      start = 1'b1;
      len = l[AW:0];
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      nrd = 0;
      while (!result_valid && cyc < 100) begin
         chk({tag, "_busy"}, busy, 1);
         if (rd_en_a) begin
            chk({tag, "_addr_a"}, rd_addr_a, nrd);
            chk({tag, "_addr_b"}, rd_addr_b, nrd);
            chk({tag, "_en_b"}, rd_en_b, 1);
            nrd++;
         end else begin
            chk({tag, "_addr_idle"}, rd_addr_a, 0);
         end
         if (poke) begin
            start = (cyc == 2);
            len = 6'd3;
         end
         if (jitter) mem_busy = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      mem_busy = 1'b0;
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_reads"}, nrd, eff);
      chk({tag, "_result"}, result, exp);
      chk({tag, "_hold_rden"}, rd_en_a, 0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({tag, "_stable"}, result, exp);
         chk({tag, "_valid_held"}, result_valid, 1);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk({tag, "_valid_drop"}, result_valid, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic [AC-1:0] e;
      int l;
      rst_n = 1'b0;
      start = 1'b0;
      len = '0;
      mem_busy = 1'b0;
      result_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_rden", {rd_en_a, rd_en_b}, 0);
      chk("rst_addr", {rd_addr_a, rd_addr_b}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         mem_a[i] = DW'(i + 1);
         mem_b[i] = DW'(i + 1);
      end
      run_job("vec1234", 4, 21'd30, 0, 1'b0, 1'b0);

      for (int i = 0; i < 32; i++) begin
         mem_a[i] = 8'hFF;
         mem_b[i] = 8'hFF;
      end
`ifdef DOTP_SIGNED_EN
      e = 21'd32;
`else
      e = 21'd2080800;
`endif
      run_job("all255", 32, e, 2, 1'b0, 1'b0);

      mem_a[0] = 8'hFF;
      mem_a[1] = 8'hFE;
      mem_b[0] = 8'd3;
      mem_b[1] = 8'd4;
`ifdef DOTP_SIGNED_EN
      e = 21'h1FFFF5;
`else
      e = 21'd1781;
`endif
      run_job("neg", 2, e, 0, 1'b0, 1'b0);

      @(negedge clk);
      mem_busy = 1'b1;
      start = 1'b1;
      len = 6'd4;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mbusy_busy", busy, 0);
         chk("mbusy_rden", rd_en_a, 0);
      end
      start = 1'b0;
      mem_busy = 1'b0;

      for (int i = 0; i < 32; i++) begin
         mem_a[i] = DW'($urandom);
         mem_b[i] = DW'($urandom);
      end
      run_job("poke", 8, model(8), 1, 1'b1, 1'b0);
      run_job("len0", 0, 21'd0, 0, 1'b0, 1'b0);
      run_job("len40", 40, model(32), 0, 1'b0, 1'b0);
      run_job("stall10", 5, model(5), 10, 1'b0, 1'b0);

      @(negedge clk);
      start = 1'b1;
      len = 6'd16;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_read_rden", rd_en_a, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rden", {rd_en_a, rd_en_b}, 0);
      chk("arst_addr", {rd_addr_a, rd_addr_b}, 0);
      chk("arst_busy", busy, 0);
      chk("arst_valid", result_valid, 0);
      chk("arst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("post_rst_valid", result_valid, 0);
         chk("post_rst_busy", busy, 0);
      end

      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < 32; i++) begin
            mem_a[i] = DW'($urandom);
            mem_b[i] = DW'($urandom);
         end
         l = $urandom_range(0, 40);
         run_job("rand", l, model((l > 32) ? 32 : l),
                 $urandom_range(0, 4), 1'b0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
